// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - sweeps x,y over 00..11 and checks two gate
// implementations against a captured 4-bit truth table.
module gate_response_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       dut_a,
  input  logic       dut_b,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tbl_q, tbl_d;
  logic [2:0] err_q, err_d;
  logic [1:0] ff_q, ff_d;
  logic       ffv_q, ffv_d;
  logic       pattern_bad;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      tbl_q   <= 4'd0;
      err_q   <= 3'd0;
      ff_q    <= 2'd0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  // A pattern counts once even when both implementations disagree.
  assign pattern_bad = (dut_a != tbl_q[idx_q]) || (dut_b != tbl_q[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          tbl_d   = expected;
          err_d   = 3'd0;
          ff_d    = 2'd0;
          ffv_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (pattern_bad) begin
          err_d = err_q + 3'd1;
          if (!ffv_q) begin
            ff_d  = idx_q;
            ffv_d = 1'b1;
          end
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign x                = idx_q[1];
  assign y                = idx_q[0];
  assign busy             = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done             = (state_q == DONE);
  assign pass             = (state_q == DONE) && (err_q == 3'd0);
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Response side of the two-input gate exercise benches.
- Drives the four input patterns x,y = 00, 01, 10, 11 into a pair of gate implementations under test: one gate-level, one expression-level.
- Samples both outputs after a settle delay and compares each against a 4-bit expected truth table.
- Reports pass/fail, the mismatch count and the first failing pattern, so every gate pair is checked by one reusable block instead of by reading a monitor printout.

Parameters:
- SETTLE, 1, number of clock cycles each pattern is held before sampling; legal range 1..15.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to run a sweep; honoured only in IDLE or DONE.
- expected  input  4  truth table; expected[{x,y}] is the required output for that pattern. Sampled on the accepted start cycle and held internally.
- dut_a  input  1  output of the gate-level implementation.
- dut_b  input  1  output of the expression-level implementation.
- x  output  1  stimulus input a to both implementations (MSB of pattern index).
- y  output  1  stimulus input b to both implementations (LSB of pattern index).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high in DONE; held until the next accepted start or reset.
- pass  output  1  valid while done = 1; 1 iff no pattern failed.
- err_count  output  3  number of failing patterns, 0..4.
- first_fail  output  2  pattern index of the first failure; valid when first_fail_valid = 1.
- first_fail_valid  output  1  set when the first failure is recorded.

Behaviour:
- Reset (synchronous, overrides everything including start): state = IDLE, pattern index = 0, x = 0, y = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail = 0, first_fail_valid = 0, settle counter = 0, stored table = 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- Start accepted (start = 1 in IDLE or DONE):
  - next state DRIVE; index = 0; x = 0, y = 0.
  - busy = 1, done = 0, pass = 0, err_count = 0, first_fail_valid = 0, first_fail = 0.
  - expected is captured.
- start is ignored while in DRIVE or SAMPLE; it does not restart or extend a sweep.
- DRIVE:
  - x, y are registered from the index bits and are stable for the whole state.
  - The state lasts exactly SETTLE cycles, counted by the settle counter from 0 to SETTLE-1, then moves to SAMPLE.
- SAMPLE, one cycle, x and y unchanged:
  - The pattern fails if dut_a != table[index] or dut_b != table[index]. One failure counts once even if both outputs mismatch.
  - On failure: err_count += 1. If first_fail_valid = 0, set first_fail = index and first_fail_valid = 1.
  - If index = 3, go to DONE. Otherwise index += 1 (x, y update on the same edge) and go to DRIVE.
  - The index never wraps within a sweep.
- DONE:
  - busy = 0, done = 1, pass = (err_count == 0), which must be correct on the first DONE cycle.
  - x, y hold 1,1; all results hold.
- Latency: start edge to first done cycle = 4*(SETTLE+1) + 1 cycles. Busy is high for 4*(SETTLE+1) cycles.
- err_count is 3 bits; the maximum value 4 cannot overflow.
- Reset mid-sweep aborts immediately to the reset values; no partial result is reported.
- dut_a and dut_b are treated as combinational functions of x, y. They are sampled only in SAMPLE; values in other states are ignored.

Test Plan:
- AND table: reset, expected = 4'b1000, DUTs are correct NAND-built AND gates, start pulse, SETTLE = 1 -> x,y step 00,01,10,11 every 2 cycles; done at start + 9 cycles; pass = 1, err_count = 0, first_fail_valid = 0.
- Single fault: expected = 4'b1000, dut_b forced to 1 when x,y = 01 -> pass = 0, err_count = 1, first_fail = 2'b01, first_fail_valid = 1.
- Double mismatch on one pattern plus later fault: dut_a and dut_b both wrong at 10, dut_a wrong at 11 -> err_count = 2, first_fail = 2'b10.
- All wrong: DUT outputs are the inverse of expected = 4'b0110 -> err_count = 4, first_fail = 0, pass = 0.
- start during sweep and restart from DONE: pulse start at cycle 3 of the sweep -> ignored, done still at start + 9. Then start again from DONE with expected = 4'b1110 (OR) and correct DUTs -> results cleared on accept, final pass = 1.
- Reset mid-sweep and SETTLE = 3: assert reset in the second DRIVE cycle -> next cycle all outputs at reset values, state IDLE. Then a full sweep takes 17 cycles to done, with x,y held 4 cycles per pattern.
